// File: rtl/envelope_generator.sv
// ADSR envelope generator: scales a strobed oscillator sample by a five-phase envelope level.
// Optional feature: define ENVELOPE_GENERATOR_BYPASS_EN to add inBypass (pass the sample through unscaled).
module envelope_generator #(
  parameter int SAMPLE_W = 12,
  parameter int LEVEL_W  = 16
) (
  input  logic                inCLK_50MHZ,
  input  logic                inRESET,
  input  logic                inGate,
  input  logic [SAMPLE_W-1:0] inSample,
  input  logic                inSampleReady,
  input  logic [LEVEL_W-1:0]  inAttackStep,
  input  logic [LEVEL_W-1:0]  inDecayStep,
  input  logic [LEVEL_W-1:0]  inSustainLevel,
  input  logic [LEVEL_W-1:0]  inReleaseStep,
`ifdef ENVELOPE_GENERATOR_BYPASS_EN
  input  logic                inBypass,
`endif
  output logic [SAMPLE_W-1:0] outSample,
  output logic                outSampleReady,
  output logic                outActive
);

  localparam int PROD_W = SAMPLE_W + LEVEL_W + 1;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } state_t;

  state_t             state;
  state_t             phase;
  state_t             next_state;
  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] next_level;
  logic               gate_prev;
  logic               gate_rise;

  logic [LEVEL_W:0]   attack_sum;
  logic [LEVEL_W:0]   decay_diff;
  logic [LEVEL_W:0]   release_diff;

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] level_ext;
  logic signed [PROD_W-1:0] product;
  logic [SAMPLE_W-1:0]      scaled;
  logic                     unused_product_bits;
  logic                     bypass_sel;

`ifdef ENVELOPE_GENERATOR_BYPASS_EN
  assign bypass_sel = inBypass;
`else
  assign bypass_sel = 1'b0;
`endif

  // Top bit of each sum/difference is the carry (attack) or borrow (decay/release).
  assign attack_sum   = {1'b0, level} + {1'b0, inAttackStep};
  assign decay_diff   = {1'b0, level} - {1'b0, inDecayStep};
  assign release_diff = {1'b0, level} - {1'b0, inReleaseStep};

  // Level is treated as unsigned by zero-extending it into the signed product.
  assign sample_ext = {{(PROD_W-SAMPLE_W){inSample[SAMPLE_W-1]}}, inSample};
  assign level_ext  = {{(PROD_W-LEVEL_W){1'b0}}, level};
  assign product    = sample_ext * level_ext;
  assign scaled     = product[LEVEL_W +: SAMPLE_W];
  assign unused_product_bits = ^{product[PROD_W-1], product[LEVEL_W-1:0]};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    gate_rise  = inGate & ~gate_prev;
    phase      = state;
    next_level = level;

    // A rise wins over gate-low; the strobe then runs the selected phase's update.
    if (gate_rise) begin
      phase = ST_ATTACK;
    end else if (!inGate && (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)) begin
      phase = ST_RELEASE;
    end
    next_state = phase;

    case (phase)
      ST_ATTACK: begin
        if (inAttackStep == '0 || attack_sum[LEVEL_W]) begin
          next_level = LEVEL_MAX;
        end else begin
          next_level = attack_sum[LEVEL_W-1:0];
        end
        if (next_level == LEVEL_MAX) next_state = ST_DECAY;
      end
      ST_DECAY: begin
        if (inDecayStep == '0 || decay_diff[LEVEL_W] ||
            decay_diff[LEVEL_W-1:0] <= inSustainLevel) begin
          next_level = inSustainLevel;
        end else begin
          next_level = decay_diff[LEVEL_W-1:0];
        end
        if (next_level == inSustainLevel) next_state = ST_SUSTAIN;
      end
      ST_SUSTAIN: begin
        next_level = inSustainLevel;
      end
      ST_RELEASE: begin
        if (inReleaseStep == '0 || release_diff[LEVEL_W]) begin
          next_level = '0;
        end else begin
          next_level = release_diff[LEVEL_W-1:0];
        end
        if (next_level == '0) next_state = ST_IDLE;
      end
      default: begin
        next_level = level;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge inCLK_50MHZ) begin
    if (inRESET) begin
      state          <= ST_IDLE;
      level          <= '0;
      gate_prev      <= 1'b0;
      outSample      <= '0;
      outSampleReady <= 1'b0;
    end else begin
      outSampleReady <= inSampleReady;
      if (inSampleReady) begin
        state     <= next_state;
        level     <= next_level;
        gate_prev <= inGate;
        // Full-scale level passes the sample through exactly instead of losing one LSB.
        outSample <= (bypass_sel || level == LEVEL_MAX) ? inSample : scaled;
      end
    end
  end

  assign outActive = (state != ST_IDLE);

endmodule

// File: tb/tb_envelope_generator.sv
// Self-checking bench for envelope_generator: directed ADSR scenarios plus randomized strobes,
// compared every cycle against an arithmetic envelope model.
module tb_envelope_generator;

  localparam int SAMPLE_W = 12;
  localparam int LEVEL_W  = 16;
  localparam int LMAX     = 65535;

  logic                inCLK_50MHZ = 1'b0;
  logic                inRESET = 1'b1;
  logic                inGate = 1'b0;
  logic [SAMPLE_W-1:0] inSample = '0;
  logic                inSampleReady = 1'b0;
  logic [LEVEL_W-1:0]  inAttackStep = '0;
  logic [LEVEL_W-1:0]  inDecayStep = '0;
  logic [LEVEL_W-1:0]  inSustainLevel = '0;
  logic [LEVEL_W-1:0]  inReleaseStep = '0;
`ifdef ENVELOPE_GENERATOR_BYPASS_EN
  logic                inBypass = 1'b0;
`endif
  logic [SAMPLE_W-1:0] outSample;
  logic                outSampleReady;
  logic                outActive;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state: phase name, integer level, last sampled gate, expected outputs.
  string m_phase = "IDLE";
  int    m_lvl   = 0;
  bit    m_gprev = 1'b0;
  int    m_out   = 0;
  bit    m_rdy   = 1'b0;

  envelope_generator #(.SAMPLE_W(SAMPLE_W), .LEVEL_W(LEVEL_W)) dut (
    .inCLK_50MHZ    (inCLK_50MHZ),
    .inRESET        (inRESET),
    .inGate         (inGate),
    .inSample       (inSample),
    .inSampleReady  (inSampleReady),
    .inAttackStep   (inAttackStep),
    .inDecayStep    (inDecayStep),
    .inSustainLevel (inSustainLevel),
    .inReleaseStep  (inReleaseStep),
`ifdef ENVELOPE_GENERATOR_BYPASS_EN
    .inBypass       (inBypass),
`endif
    .outSample      (outSample),
    .outSampleReady (outSampleReady),
    .outActive      (outActive)
  );

  always #10 inCLK_50MHZ = ~inCLK_50MHZ;

  task automatic check(input string name, input integer act, input integer exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Envelope rules in plain integer arithmetic, evaluated once per clock edge.
  task automatic model_step();
    int    s;
    int    a, d, sus, r;
    string ph;
    longint p;
    if (inRESET) begin
      m_phase = "IDLE"; m_lvl = 0; m_gprev = 1'b0; m_out = 0; m_rdy = 1'b0;
      return;
    end
    m_rdy = inSampleReady;
    if (!inSampleReady) return;
    s   = $signed(inSample);
    a   = int'(inAttackStep);
    d   = int'(inDecayStep);
    sus = int'(inSustainLevel);
    r   = int'(inReleaseStep);
    p   = longint'(s) * longint'(m_lvl);
    m_out = (m_lvl == LMAX) ? s : int'(p >>> LEVEL_W);
`ifdef ENVELOPE_GENERATOR_BYPASS_EN
    if (inBypass) m_out = s;
`endif
    ph = m_phase;
    if (inGate && !m_gprev) ph = "ATTACK";
    else if (!inGate && (ph == "ATTACK" || ph == "DECAY" || ph == "SUSTAIN")) ph = "RELEASE";
    if (ph == "ATTACK") begin
      m_lvl = (a == 0) ? LMAX : ((m_lvl + a > LMAX) ? LMAX : m_lvl + a);
      if (m_lvl == LMAX) ph = "DECAY";
    end else if (ph == "DECAY") begin
      m_lvl = (d == 0) ? sus : ((m_lvl - d < sus) ? sus : m_lvl - d);
      if (m_lvl == sus) ph = "SUSTAIN";
    end else if (ph == "SUSTAIN") begin
      m_lvl = sus;
    end else if (ph == "RELEASE") begin
      m_lvl = (r == 0) ? 0 : ((m_lvl - r < 0) ? 0 : m_lvl - r);
      if (m_lvl == 0) ph = "IDLE";
    end
    m_phase = ph;
    m_gprev = inGate;
  endtask

  always @(negedge inCLK_50MHZ) begin
    if (cmp_en) begin
      check("ready", outSampleReady, m_rdy);
      check("active", outActive, (m_phase != "IDLE"));
      check("sample", $signed(outSample), m_out);
    end
  end

  task automatic step(input logic g, input logic stb, input int s, input logic rst);
    inGate        = g;
    inSampleReady = stb;
    inSample      = s[SAMPLE_W-1:0];
    inRESET       = rst;
    @(posedge inCLK_50MHZ);
    model_step();
    @(negedge inCLK_50MHZ);
  endtask

  task automatic strobe(input logic g, input int s, input int gap);
    step(g, 1'b1, s, 1'b0);
    repeat (gap) step(g, 1'b0, int'($urandom_range(0, 4095)), 1'b0);
  endtask

  initial begin
    cmp_en = 1'b1;
    repeat (3) step(1'b0, 1'b1, 77, 1'b1);
    check("reset_sample", $signed(outSample), 0);
    check("reset_ready", outSampleReady, 0);
    check("reset_active", outActive, 0);

    // Idle strobe with the gate low: level 0 scales everything to zero.
    inAttackStep = 16'h4000; inDecayStep = 16'h1000;
    inSustainLevel = 16'h8000; inReleaseStep = 16'h2000;
    step(1'b0, 1'b1, 1000, 1'b0);
    check("idle_sample", $signed(outSample), 0);
    check("idle_ready_pulse", outSampleReady, 1);
    check("idle_active", outActive, 0);
    step(1'b0, 1'b0, 0, 1'b0);
    check("idle_ready_drop", outSampleReady, 0);

    // Full attack and decay into sustain at the nominal 40 kHz strobe spacing.
    for (int k = 1; k <= 12; k++) begin
      strobe(1'b1, (k == 5) ? 2047 : 1000, 1249);
      if (k == 4) begin
        check("model_attack_peak", m_lvl, 32'hFFFF);
        check("model_enter_decay", (m_phase == "DECAY"), 1);
      end
      if (k == 5) begin
        check("unity_during_decay", $signed(outSample), 2047);
        check("model_first_decay", m_lvl, 32'hEFFF);
      end
    end
    check("model_sustain_level", m_lvl, 32'h8000);
    check("model_sustain_phase", (m_phase == "SUSTAIN"), 1);
    check("sustain_active", outActive, 1);

    // Half-scale sample, then four release strobes down to idle.
    strobe(1'b1, -2048, 2);
    check("half_scale", $signed(outSample), -1024);
    for (int k = 1; k <= 4; k++) begin
      strobe(1'b0, 0, 2);
      if (k == 3) check("release_still_active", outActive, 1);
    end
    check("release_done_idle", outActive, 0);

    // Instant attack to full scale and sustain at full scale: unity gain both signs.
    inAttackStep = 16'h0000; inSustainLevel = 16'hFFFF;
    strobe(1'b1, 1000, 1);
    strobe(1'b1, 2047, 0);
    check("unity_pos", $signed(outSample), 2047);
    strobe(1'b1, -2048, 1);
    check("unity_neg", $signed(outSample), -2048);

    // Zero release step drops straight to idle.
    inReleaseStep = 16'h0000;
    strobe(1'b0, 0, 1);
    check("instant_release_idle", outActive, 0);

    // Retrigger from a partial level without resetting it.
    inAttackStep = 16'h4000; inDecayStep = 16'h3FFF; inSustainLevel = 16'h8000;
    for (int k = 0; k < 5; k++) strobe(1'b1, 100, 0);
    inReleaseStep = 16'h2000;
    strobe(1'b0, 100, 0);
    check("model_retrigger_base", m_lvl, 32'hA000);
    inAttackStep = 16'h0000;
    strobe(1'b1, 2000, 0);
    check("retrigger_keeps_level", $signed(outSample), 1250);
    strobe(1'b1, 2047, 0);
    check("retrigger_instant_peak", $signed(outSample), 2047);

    // Reset coincident with a strobe in the middle of an attack.
    inReleaseStep = 16'h0000;
    strobe(1'b0, 0, 0);
    inAttackStep = 16'h1000;
    for (int k = 0; k < 3; k++) strobe(1'b1, 500, 0);
    step(1'b1, 1'b1, 500, 1'b1);
    check("reset_strobe_no_ready", outSampleReady, 0);
    check("reset_strobe_idle", outActive, 0);
    step(1'b1, 1'b0, 0, 1'b0);
    strobe(1'b1, 2000, 0);
    check("post_reset_from_zero", $signed(outSample), 0);
    check("post_reset_attack", outActive, 1);

`ifdef ENVELOPE_GENERATOR_BYPASS_EN
    inBypass = 1'b1;
    strobe(1'b1, -5, 0);
    check("bypass_passthrough", $signed(outSample), -5);
    inBypass = 1'b0;
`endif

    // Randomized traffic: back-to-back strobes, live step/sustain changes, sporadic resets.
    for (int c = 0; c < 4000; c++) begin
      logic g;
      g = inGate;
      if ($urandom_range(0, 9) == 0) g = ~g;
      if ($urandom_range(0, 49) == 0) begin
        inAttackStep  = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h4000));
        inDecayStep   = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h4000));
        inReleaseStep = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h4000));
      end
      if ($urandom_range(0, 39) == 0) inSustainLevel = 16'($urandom_range(0, 16'hFFFF));
`ifdef ENVELOPE_GENERATOR_BYPASS_EN
      inBypass = ($urandom_range(0, 7) == 0);
`endif
      step(g, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 4095)),
           ($urandom_range(0, 299) == 0));
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/envelope_generator.md
ENVELOPE_GENERATOR -- requirements
Module: envelope_generator

Interface
REQ-001 Parameter SAMPLE_W, default 12, sample width in bits.
REQ-002 Parameter LEVEL_W, default 16, envelope level and step width in bits.
REQ-003 Port inCLK_50MHZ  input  1  system clock, all logic on rising edge.
REQ-004 Port inRESET  input  1  synchronous, active-high reset.
REQ-005 Port inGate  input  1  note gate, 1 = key held.
REQ-006 Port inSample  input  SAMPLE_W  oscillator sample, two's complement.
REQ-007 Port inSampleReady  input  1  one-cycle strobe qualifying inSample, about 40 kHz.
REQ-008 Port inAttackStep  input  LEVEL_W  level increment per strobe in ATTACK.
REQ-009 Port inDecayStep  input  LEVEL_W  level decrement per strobe in DECAY.
REQ-010 Port inSustainLevel  input  LEVEL_W  SUSTAIN hold level.
REQ-011 Port inReleaseStep  input  LEVEL_W  level decrement per strobe in RELEASE.
REQ-012 Port outSample  output  SAMPLE_W  scaled sample, two's complement.
REQ-013 Port outSampleReady  output  1  one-cycle strobe qualifying outSample.
REQ-014 Port outActive  output  1  high whenever state is not IDLE.

Function
REQ-015 Internal state, level, gate history and outputs shall change only on cycles where inSampleReady=1; outSampleReady is the only exception and is driven low on every other cycle.
REQ-016 The FSM shall have five states: IDLE, ATTACK, DECAY, SUSTAIN and RELEASE.
REQ-017 The gate shall be sampled only on strobe cycles. A rise is inGate=1 while the previous sampled gate was 0.
REQ-018 A gate rise in any state shall enter ATTACK, keeping the current level as a retrigger with no reset to 0.
REQ-019 inGate=0 while in ATTACK, DECAY or SUSTAIN shall enter RELEASE on that strobe.
REQ-020 ATTACK: level shall become min(level+inAttackStep, 2^LEVEL_W-1), computed with a carry bit. On reaching max, the state shall become DECAY.
REQ-021 DECAY: level shall become max(level-inDecayStep, inSustainLevel). On reaching inSustainLevel, the state shall become SUSTAIN.
REQ-022 SUSTAIN: level shall equal the current inSustainLevel on every strobe, tracking live changes.
REQ-023 RELEASE: level shall become max(level-inReleaseStep, 0). On reaching 0, the state shall become IDLE.
REQ-024 A step value of 0 shall mean an instantaneous jump to that phase's target on the same strobe.
REQ-025 Gate rise shall take priority over gate-low and over all step transitions on the same strobe.
REQ-026 Scaling shall use the level held before the strobe's update. outSample = (inSample * {0,level}) >>> LEVEL_W, arithmetic shift, keeping the low SAMPLE_W bits.
REQ-027 When level = 2^LEVEL_W-1, outSample shall equal inSample exactly (unity).
REQ-028 Latency: outSample and outSampleReady=1 shall appear exactly 1 cycle after the inSampleReady strobe. outSample shall hold until the next output strobe.
REQ-029 Back-to-back strobes on consecutive cycles shall each produce one output strobe, with no drop.

Reset
REQ-030 When inRESET=1 at a clock edge: state=IDLE, level=0, previous gate=0, outSample=0, outSampleReady=0, outActive=0.
REQ-031 Reset shall override a simultaneous strobe. The first strobe after reset release shall behave as if from IDLE.
REQ-032 Reset mid-envelope shall abort immediately, with no release tail.

Configuration
REQ-033 Macro ENVELOPE_GENERATOR_BYPASS_EN, when defined, shall add port inBypass, input, width 1. inBypass=1 shall make outSample=inSample with the same 1-cycle latency, while the FSM and level keep running.
REQ-034 Without ENVELOPE_GENERATOR_BYPASS_EN, inBypass shall be absent and scaling shall always apply.

Verification
REQ-035 Reset, then strobe with inSample=1000 and inGate=0 -> outSample=0 one cycle later, outSampleReady pulse 1 cycle, outActive=0.
REQ-036 Steps A=0x4000, D=0x1000, S=0x8000, R=0x2000, inGate=1, strobes every 1250 cycles -> levels 0x4000, 0x8000, 0xC000, 0xFFFF (ATTACK), then 0xEFFF ... down to 0x8000 (DECAY to SUSTAIN), outActive=1.
REQ-037 In SUSTAIN with level 0x8000, then inGate=0 -> RELEASE reaches 0 after 4 strobes, IDLE, outActive=0; inSample=-2048 at level 0x8000 -> outSample=-1024.
REQ-038 Level 0xFFFF, inSample=2047 then -2048 -> outSample 2047 then -2048, unity.
REQ-039 Gate low then high on the next strobe during DECAY at level 0xA000 -> ATTACK from 0xA000; inAttackStep=0 -> level 0xFFFF on that strobe.
REQ-040 Assert inRESET mid-ATTACK coincident with a strobe -> no output strobe, level=0, IDLE. With the macro defined and inBypass=1, inSample=-5 -> outSample=-5.
